load_scoreboard: RTL and testbench

Pipeline hazard controller for the 5-stage RV32I core. It tracks destination registers of loads that have left Decode but whose variable-latency data-memory response has not yet been written back. It produces the Fetch/Decode stall and Decode/Execute flush controls, and bounds the number of loads in flight. It sits beside Decode, reads the decoded register fields, and observes the memory response at Writeback.

---
 rtl/load_scoreboard.sv | 96 +++++++++
 tb/tb_load_scoreboard.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/load_scoreboard.sv
// Load scoreboard: tracks destination registers of in-flight loads and
// generates Fetch/Decode stall and Decode/Execute flush controls.
module load_scoreboard #(
  parameter int MAX_OUT = 4,
  parameter int CW      = $clog2(MAX_OUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ValidD,
  input  logic [4:0]    Rs1D,
  input  logic [4:0]    Rs2D,
  input  logic [4:0]    RdD,
  input  logic          UsesRs1D,
  input  logic          UsesRs2D,
  input  logic          WritesRdD,
  input  logic          LoadD,
  input  logic          PCSrcE,
  input  logic          LdRespW,
  input  logic [4:0]    LdRdW,
  output logic          StallF,
  output logic          StallD,
  output logic          FlushD,
  output logic          FlushE,
  output logic [31:0]   Pending,
  output logic [CW-1:0] OutCnt,
  output logic [31:0]   StallCycles,
  output logic          ScbErr
);

  logic [31:0]   r_pending;
  logic [CW-1:0] r_outcnt;
  logic [31:0]   r_stall_cycles;
  logic          r_err;

  logic          w_raw;
  logic          w_waw;
  logic          w_cap;
  logic          w_hazard;
  logic          w_issue;
  logic          w_retire;
  logic          w_resp_err;
  logic [31:0]   w_pend_nxt;
  logic [CW-1:0] w_cnt_nxt;

  // Hazard detection, issue/retire qualification and pipeline controls
  always_comb begin
    w_raw    = ValidD & ((UsesRs1D & r_pending[Rs1D]) |
                         (UsesRs2D & r_pending[Rs2D]));
    w_waw    = ValidD & WritesRdD & r_pending[RdD];
    w_retire = LdRespW & (LdRdW != 5'd0) & r_pending[LdRdW];
    // A retire in the same cycle frees a slot, so a full scoreboard does not
    // block the new load; issue+retire then leaves the count at MAX_OUT.
    w_cap    = ValidD & LoadD & (r_outcnt == CW'(MAX_OUT)) & ~w_retire;
    w_hazard = (w_raw | w_waw | w_cap) & ~PCSrcE;
    w_issue  = ValidD & LoadD & WritesRdD & (RdD != 5'd0) & ~w_hazard & ~PCSrcE;
    w_resp_err = LdRespW & (LdRdW != 5'd0) & ~r_pending[LdRdW];
    StallF   = w_hazard;
    StallD   = w_hazard;
    FlushD   = PCSrcE;
    FlushE   = w_hazard | PCSrcE;
  end

  // Next scoreboard bitmap and outstanding count; set is applied after clear
  always_comb begin
    w_pend_nxt = r_pending;
    if (w_retire) w_pend_nxt[LdRdW] = 1'b0;
    if (w_issue)  w_pend_nxt[RdD]   = 1'b1;
    w_pend_nxt[0] = 1'b0;
    w_cnt_nxt = r_outcnt;
    if (w_issue && !w_retire)      w_cnt_nxt = r_outcnt + CW'(1);
    else if (!w_issue && w_retire) w_cnt_nxt = r_outcnt - CW'(1);
  end

  // State registers: bitmap, count, saturating stall counter, sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending      <= '0;
      r_outcnt       <= '0;
      r_stall_cycles <= '0;
      r_err          <= 1'b0;
    end else begin
      r_pending <= w_pend_nxt;
      r_outcnt  <= w_cnt_nxt;
      if (w_hazard && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_resp_err)
        r_err <= 1'b1;
    end
  end

  assign Pending     = r_pending;
  assign OutCnt      = r_outcnt;
  assign StallCycles = r_stall_cycles;
  assign ScbErr      = r_err;

endmodule

// File: tb/tb_load_scoreboard.sv
// Directed testbench for load_scoreboard (MAX_OUT = 4).
module tb_load_scoreboard;

  logic        clk;
  logic        rst;
  logic        ValidD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        UsesRs1D, UsesRs2D, WritesRdD, LoadD;
  logic        PCSrcE;
  logic        LdRespW;
  logic [4:0]  LdRdW;
  logic        StallF, StallD, FlushD, FlushE;
  logic [31:0] Pending;
  logic [2:0]  OutCnt;
  logic [31:0] StallCycles;
  logic        ScbErr;

  int checks   = 0;
  int failures = 0;

  load_scoreboard #(.MAX_OUT(4)) dut (
    .clk(clk), .rst(rst), .ValidD(ValidD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .UsesRs1D(UsesRs1D), .UsesRs2D(UsesRs2D), .WritesRdD(WritesRdD), .LoadD(LoadD),
    .PCSrcE(PCSrcE), .LdRespW(LdRespW), .LdRdW(LdRdW),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .Pending(Pending), .OutCnt(OutCnt), .StallCycles(StallCycles), .ScbErr(ScbErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ValidD = 0; Rs1D = 0; Rs2D = 0; RdD = 0;
    UsesRs1D = 0; UsesRs2D = 0; WritesRdD = 0; LoadD = 0;
    PCSrcE = 0; LdRespW = 0; LdRdW = 0;
  endtask

  task automatic dec_load(input logic [4:0] rd, input logic [4:0] rs1);
    ValidD = 1; LoadD = 1; WritesRdD = 1; RdD = rd;
    UsesRs1D = 1; Rs1D = rs1; UsesRs2D = 0; Rs2D = 0;
  endtask

  task automatic resp(input logic [4:0] rd);
    LdRespW = 1; LdRdW = rd;
  endtask

  initial begin
    rst = 0;
    idle();
    #3;
    // Reset state
    check("rst_pending", Pending, 32'h0);
    check("rst_outcnt", {29'd0, OutCnt}, 32'd0);
    check("rst_stallcyc", StallCycles, 32'd0);
    check("rst_err", {31'd0, ScbErr}, 32'd0);
    check("rst_ctrl", {28'd0, StallF, StallD, FlushD, FlushE}, 32'h0);
    @(posedge clk); #1;
    rst = 1;
    tick();

    // Load-use: lw x5 issues, add x6,x5,x1 stalls 3 cycles
    dec_load(5'd5, 5'd0); #1;
    check("lu_issue_nostall", {31'd0, StallD}, 32'd0);
    tick();
    idle();
    ValidD = 1; UsesRs1D = 1; Rs1D = 5; UsesRs2D = 1; Rs2D = 1; WritesRdD = 1; RdD = 6;
    #1;
    check("lu_pending5", Pending, 32'h0000_0020);
    check("lu_stall_c1", {30'd0, StallD, FlushE}, 32'h3);
    tick();
    check("lu_stall_c2", {30'd0, StallF, FlushE}, 32'h3);
    tick();
    resp(5'd5); #1;
    check("lu_stall_retire_cycle", {31'd0, StallD}, 32'd1);
    tick();
    LdRespW = 0; LdRdW = 0; #1;
    check("lu_proceed", {31'd0, StallD}, 32'd0);
    check("lu_stallcyc", StallCycles, 32'd3);
    check("lu_pending_clr", Pending, 32'h0);
    tick();

    // Capacity: four loads x1..x4 fill the scoreboard
    for (int i = 1; i <= 4; i++) begin
      idle(); dec_load(5'(i), 5'd0);
      tick();
    end
    idle(); dec_load(5'd7, 5'd0); #1;
    check("cap_pending", Pending, 32'h0000_001E);
    check("cap_outcnt", {29'd0, OutCnt}, 32'd4);
    check("cap_stall", {31'd0, StallD}, 32'd1);
    tick();
    resp(5'd2); #1;
    check("cap_retire_nostall", {31'd0, StallD}, 32'd0);
    tick();
    idle(); #1;
    check("cap_outcnt_stays", {29'd0, OutCnt}, 32'd4);
    check("cap_pending2", Pending, 32'h0000_009A);
    check("cap_stallcyc", StallCycles, 32'd4);

    // Drain x1, x3, x4, x7
    resp(5'd1); tick();
    resp(5'd3); tick();
    resp(5'd4); tick();
    resp(5'd7); tick();
    idle(); #1;
    check("drain_outcnt", {29'd0, OutCnt}, 32'd0);
    check("drain_pending", Pending, 32'h0);

    // WAW: lw x9 twice
    dec_load(5'd9, 5'd0); tick();
    #1;
    check("waw_stall", {31'd0, StallD}, 32'd1);
    tick();
    resp(5'd9); #1;
    check("waw_stall_retire_cycle", {31'd0, StallD}, 32'd1);
    tick();
    LdRespW = 0; LdRdW = 0; #1;
    check("waw_proceed", {31'd0, StallD}, 32'd0);
    check("waw_pending_clr", Pending, 32'h0);
    tick();
    idle(); #1;
    check("waw_pending_reset", Pending, 32'h0000_0200);
    check("waw_outcnt", {29'd0, OutCnt}, 32'd1);
    check("waw_stallcyc", StallCycles, 32'd6);

    // Branch overrides RAW: lw x10,0(x9) with PCSrcE
    dec_load(5'd10, 5'd9); PCSrcE = 1; #1;
    check("br_ctrl", {28'd0, StallF, StallD, FlushD, FlushE}, 32'h3);
    tick();
    idle(); #1;
    check("br_no_issue", Pending, 32'h0000_0200);
    check("br_stallcyc", StallCycles, 32'd6);

    // x0 destination and response handling
    dec_load(5'd0, 5'd0); tick();
    idle(); resp(5'd0); tick();
    idle(); #1;
    check("x0_pending", Pending, 32'h0000_0200);
    check("x0_outcnt", {29'd0, OutCnt}, 32'd1);
    check("x0_resp_noerr", {31'd0, ScbErr}, 32'd0);
    resp(5'd12); tick();
    idle(); #1;
    check("err_set", {31'd0, ScbErr}, 32'd1);
    check("err_pending", Pending, 32'h0000_0200);
    check("err_outcnt", {29'd0, OutCnt}, 32'd1);
    tick();
    check("err_sticky", {31'd0, ScbErr}, 32'd1);

    // Async reset with three loads outstanding
    dec_load(5'd11, 5'd0); tick();
    dec_load(5'd13, 5'd0); tick();
    idle(); #1;
    check("ar_outcnt3", {29'd0, OutCnt}, 32'd3);
    #1; rst = 0; #1;
    check("ar_pending", Pending, 32'h0);
    check("ar_outcnt", {29'd0, OutCnt}, 32'd0);
    check("ar_err", {31'd0, ScbErr}, 32'd0);
    check("ar_stallcyc", StallCycles, 32'd0);
    @(posedge clk); #1;
    rst = 1;
    resp(5'd11); tick();
    idle(); #1;
    check("ar_late_resp_err", {31'd0, ScbErr}, 32'd1);
    check("ar_late_outcnt", {29'd0, OutCnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
